// File: rtl/peripheral_msi_slave_port_arbiter_ahb3.sv
// -----------------------------------------------------------------------------
// peripheral_msi_slave_port_arbiter_ahb3
//
// Per-slave arbiter for the AHB3 multi-layer interconnect (one instance per
// slave). It collects the slave-select requests of every master port and keeps
// exactly one master granted at all times; with no requests the grant parks on
// the last owner.
//
// Arbitration:
//   - The highest priority among requesting masters wins.
//   - Ties go to the first candidate in ring order after the current owner,
//     so the owner is considered last.
//   - Ownership moves only at a legal switch point: the slave is ready, and
//     the owner either allows a switch (can_switch) or no longer requests.
//
// Ports:
//   HRESETn         in   async reset, active-low
//   HCLK            in   bus clock
//   mst_req         in   [MASTERS]      request per master port
//   mst_priority    in   [MASTERS][3]   per-master priority, 7 = highest
//   mst_can_switch  in   [MASTERS]      owner may release the bus
//   slv_HREADY      in   slave HREADYOUT; switching only while high
//   master_granted  out  [MASTERS]      one-hot grant (registered)
//   master_sel      out  [clog2]        binary index of the granted master
//   grant_switch    out  one-cycle pulse, grant changed at the last edge
// -----------------------------------------------------------------------------
module peripheral_msi_slave_port_arbiter_ahb3 #(
  parameter int MASTERS = 5,
  parameter int SEL_W   = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                          HRESETn,
  input  logic                          HCLK,
  input  logic [MASTERS-1:0]            mst_req,
  input  logic [MASTERS-1:0][2:0]       mst_priority,
  input  logic [MASTERS-1:0]            mst_can_switch,
  input  logic                          slv_HREADY,
  output logic [MASTERS-1:0]            master_granted,
  output logic [SEL_W-1:0]              master_sel,
  output logic                          grant_switch
);

  // Index 'step' positions after 'base' around the ring of masters.
  function automatic logic [SEL_W-1:0] ring_index(input logic [SEL_W-1:0] base,
                                                  input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= MASTERS) begin
      sum = sum - MASTERS;
    end else begin
      sum = sum;
    end
    return sum[SEL_W-1:0];
  endfunction

  // One-hot encoding of a master index.
  function automatic logic [MASTERS-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [MASTERS-1:0] vec;
    vec      = {MASTERS{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  localparam logic [MASTERS-1:0] PARK_GRANT = {{(MASTERS-1){1'b0}}, 1'b1};

  logic [MASTERS-1:0] grant_r;
  logic [SEL_W-1:0]   owner_r;
  logic               switch_r;

  logic [2:0]         maxp_s;
  logic [SEL_W-1:0]   winner_s;
  logic               found_s;
  logic               sw_s;
  logic [SEL_W-1:0]   cand_s;

  // Highest priority among requesting masters; non-requesters are ignored.
  always_comb begin
    maxp_s = 3'd0;
    for (int i = 0; i < MASTERS; i++) begin
      if (mst_req[i] && (mst_priority[i] > maxp_s)) begin
        maxp_s = mst_priority[i];
      end else begin
        maxp_s = maxp_s;
      end
    end
  end

  // Ring search starting after the owner; the owner itself is visited last
  // (step == MASTERS), which gives round-robin among equal priorities.
  always_comb begin
    winner_s = owner_r;
    found_s  = 1'b0;
    cand_s   = owner_r;
    for (int k = 1; k <= MASTERS; k++) begin
      cand_s = ring_index(owner_r, k);
      if (!found_s && mst_req[cand_s] && (mst_priority[cand_s] == maxp_s)) begin
        winner_s = cand_s;
        found_s  = 1'b1;
      end else begin
        winner_s = winner_s;
        found_s  = found_s;
      end
    end
  end

  // Legal switch point: slave ready, somebody requests, and the owner either
  // releases voluntarily or has dropped its request (locked bursts hold here).
  always_comb begin
    sw_s = slv_HREADY & (|mst_req) & (mst_can_switch[owner_r] | ~mst_req[owner_r]);
  end

  // Grant register: moves to the winner at a switch point, otherwise parks.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_r  <= PARK_GRANT;
      owner_r  <= {SEL_W{1'b0}};
      switch_r <= 1'b0;
    end else if (sw_s && found_s && (winner_s != owner_r)) begin
      grant_r  <= onehot(winner_s);
      owner_r  <= winner_s;
      switch_r <= 1'b1;
    end else begin
      grant_r  <= grant_r;
      owner_r  <= owner_r;
      switch_r <= 1'b0;
    end
  end

  assign master_granted = grant_r;
  assign master_sel     = owner_r;
  assign grant_switch   = switch_r;

endmodule

// File: tb/tb_peripheral_msi_slave_port_arbiter_ahb3.sv
// -----------------------------------------------------------------------------
// Testbench for peripheral_msi_slave_port_arbiter_ahb3 (MASTERS = 5).
// Each driven cycle pushes the expected grant state into a scoreboard queue;
// after the next clock edge the entry is popped and compared with the DUT.
// Directed constant checks cover the reset state and the listed scenarios.
// -----------------------------------------------------------------------------
module tb_peripheral_msi_slave_port_arbiter_ahb3;

  typedef struct {
    logic [4:0] grant;
    logic [2:0] sel;
    logic       sw;
  } exp_t;

  logic            HRESETn;
  logic            HCLK;
  logic [4:0]      mst_req;
  logic [4:0][2:0] mst_priority;
  logic [4:0]      mst_can_switch;
  logic            slv_HREADY;
  logic [4:0]      master_granted;
  logic [2:0]      master_sel;
  logic            grant_switch;

  exp_t sb[$];
  int   m_owner;
  int   n_cmp;
  int   n_fail;

  peripheral_msi_slave_port_arbiter_ahb3 #(.MASTERS(5)) dut (
    .HRESETn        (HRESETn),
    .HCLK           (HCLK),
    .mst_req        (mst_req),
    .mst_priority   (mst_priority),
    .mst_can_switch (mst_can_switch),
    .slv_HREADY     (slv_HREADY),
    .master_granted (master_granted),
    .master_sel     (master_sel),
    .grant_switch   (grant_switch)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict the post-edge state, then compare.
  task automatic step(input logic [4:0] req, input logic [4:0] cs, input logic rdy);
    exp_t e;
    exp_t got;
    int   best;
    logic sw;
    mst_req        = req;
    mst_can_switch = cs;
    slv_HREADY     = rdy;
    best = -1;
    for (int p = 7; p >= 0; p--) begin
      for (int k = 1; k <= 5; k++) begin
        int idx;
        idx = (m_owner + k) % 5;
        if (best < 0 && req[idx] && int'(mst_priority[idx]) == p) best = idx;
      end
    end
    sw   = rdy && (req != 5'b00000) && (cs[m_owner] || !req[m_owner]);
    e.sw = 1'b0;
    if (sw && best >= 0 && best != m_owner) begin
      m_owner = best;
      e.sw    = 1'b1;
    end
    e.grant = 5'b00001 << m_owner;
    e.sel   = 3'(m_owner);
    sb.push_back(e);
    @(posedge HCLK);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check("sb_grant",  32'(master_granted), 32'(got.grant));
      check("sb_sel",    32'(master_sel),     32'(got.sel));
      check("sb_switch", 32'(grant_switch),   32'(got.sw));
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    m_owner        = 0;
    HRESETn        = 1'b0;
    mst_req        = 5'b00000;
    mst_priority   = '{default: 3'd0};
    mst_can_switch = 5'b00000;
    slv_HREADY     = 1'b1;

    // 1. reset state, then 20 idle cycles
    #12;
    check("rst_grant",  32'(master_granted), 32'h01);
    check("rst_sel",    32'(master_sel),     32'h0);
    check("rst_switch", 32'(grant_switch),   32'h0);
    #10;
    HRESETn = 1'b1;
    for (int i = 0; i < 20; i++) step(5'b00000, 5'b00000, 1'b1);
    check("idle_grant", 32'(master_granted), 32'h01);

    // 2. single request from master 2
    mst_priority[2] = 3'd3;
    step(5'b00100, 5'b00001, 1'b1);
    check("t2_grant",  32'(master_granted), 32'h04);
    check("t2_sel",    32'(master_sel),     32'h2);
    check("t2_switch", 32'(grant_switch),   32'h1);
    step(5'b00100, 5'b00000, 1'b1);
    check("t2_pulse_end", 32'(grant_switch), 32'h0);

    // 3. locked burst on master 2 while master 4 requests at priority 7
    mst_priority[4] = 3'd7;
    for (int i = 0; i < 8; i++) step(5'b10100, 5'b00000, 1'b1);
    check("t3_hold", 32'(master_granted), 32'h04);
    step(5'b10100, 5'b00100, 1'b1);
    check("t3_move", 32'(master_granted), 32'h10);
    check("t3_sel",  32'(master_sel),     32'h4);

    // 4. round robin among equal priorities 1, 3, 4
    mst_priority[1] = 3'd5;
    mst_priority[3] = 3'd5;
    mst_priority[4] = 3'd5;
    step(5'b11010, 5'b11111, 1'b1);
    check("t4_rr1", 32'(master_granted), 32'h02);
    step(5'b11010, 5'b11111, 1'b1);
    check("t4_rr3", 32'(master_granted), 32'h08);
    step(5'b11010, 5'b11111, 1'b1);
    check("t4_rr4", 32'(master_granted), 32'h10);
    step(5'b11010, 5'b11111, 1'b1);
    check("t4_rr1b", 32'(master_granted), 32'h02);

    // 5. wait states block the switch from owner 1 to master 3
    for (int i = 0; i < 3; i++) step(5'b01010, 5'b11111, 1'b0);
    check("t5_wait", 32'(master_granted), 32'h02);
    step(5'b01010, 5'b11111, 1'b1);
    check("t5_move", 32'(master_granted), 32'h08);

    // 6. asynchronous reset in the middle of a burst on master 3
    for (int i = 0; i < 3; i++) step(5'b01000, 5'b00000, 1'b1);
    #2;
    HRESETn = 1'b0;
    #1;
    check("t6_async_grant",  32'(master_granted), 32'h01);
    check("t6_async_sel",    32'(master_sel),     32'h0);
    check("t6_async_switch", 32'(grant_switch),   32'h0);
    m_owner = 0;
    @(posedge HCLK);
    #1;
    check("t6_held_grant", 32'(master_granted), 32'h01);
    HRESETn = 1'b1;

    // strict priority: master 1 at 6 beats master 2 at 2 from parked owner 0
    mst_priority[1] = 3'd6;
    mst_priority[2] = 3'd2;
    step(5'b00110, 5'b00001, 1'b1);
    check("prio_strict", 32'(master_granted), 32'h02);

    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      for (int m = 0; m < 5; m++) mst_priority[m] = 3'($urandom_range(7, 0));
      step(5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)),
           1'($urandom_range(3, 0) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
